// File: rtl/mux_2to1_if.sv
// mux_2to1_if: bundles the data inputs, select line and both outputs of the
// 2:1 word multiplexer. The master side drives a, b and sel; the slave side
// (the mux itself) drives y and y_q.
interface mux_2to1_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;

    modport master (
        output a,
        output b,
        output sel,
        input  y,
        input  y_q
    );

    modport slave (
        input  a,
        input  b,
        input  sel,
        output y,
        output y_q
    );
endinterface

// File: rtl/mux_2to1.sv
// mux_2to1: whole-word 2:1 multiplexer for datapath selection points.
//   sel = 1 -> y = a, sel = 0 -> y = b, purely combinational.
// Optional feature macro: MUX_OUTPUT_REG_EN
//   defined   : y_q is y delayed by one clk edge, synchronous active-high
//               reset to 0 (reset wins over capture).
//   undefined : no flops; y_q is wired straight to y and clk/rst are unused.
// The port list is the same in both builds.
module mux_2to1 #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    mux_2to1_if.slave  bus
);

    // Stage 0: combinational select. The conditional operator is used on
    // purpose so an unknown sel merges a and b bitwise in simulation instead
    // of being coerced to one side.
    logic [WIDTH-1:0] y_p0;

    assign y_p0  = bus.sel ? bus.a : bus.b;
    assign bus.y = y_p0;

`ifdef MUX_OUTPUT_REG_EN
    // Stage 1: registered copy of the selected word.
    logic [WIDTH-1:0] y_p1;

    // Capture the selected word every edge; reset forces zero and has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= y_p0;
        end
    end

    assign bus.y_q = y_p1;
`else
    // Pass-through build: y_q follows y with zero latency. clk and rst stay on
    // the port list for a uniform interface but drive nothing.
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign bus.y_q        = y_p0;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed plus randomized checks of mux_2to1 against a
// behavioural model (bit-mask selection and a one-deep history register).
// Works for both builds of MUX_OUTPUT_REG_EN.
module tb_mux_2to1;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_2to1_if #(.WIDTH(WIDTH)) bus ();

    mux_2to1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Currently applied stimulus and model state.
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic             cur_sel;
    logic             cur_rst;
    logic [WIDTH-1:0] model_q;
    bit               model_known = 1'b0;
    bit               four_state;

    // Reference selection: mask arithmetic rather than a conditional.
    function automatic logic [WIDTH-1:0] ref_sel(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic sel);
        logic [WIDTH-1:0] m;
        m = {WIDTH{sel}};
        return (a & m) | (b & ~m);
    endfunction

    // Expected y_q given the model history and the present inputs.
    function automatic logic [WIDTH-1:0] exp_q();
`ifdef MUX_OUTPUT_REG_EN
        return model_q;
`else
        return ref_sel(cur_a, cur_b, cur_sel);
`endif
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge: history register takes the pre-edge word or zero.
    task automatic clock_edge(input string tag);
        logic [WIDTH-1:0] pre;
        pre = ref_sel(cur_a, cur_b, cur_sel);
        @(posedge clk);
        model_q     = cur_rst ? '0 : pre;
        model_known = 1'b1;
        #1;
        check({tag, "_yq_post"}, bus.y_q, exp_q());
    endtask

    // Apply inputs away from the edge, check outputs, then clock once.
    task automatic apply(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sel, input logic r, input string tag);
        @(negedge clk);
        cur_a = a; cur_b = b; cur_sel = sel; cur_rst = r;
        bus.a = a; bus.b = b; bus.sel = sel; rst = r;
        #1;
        check({tag, "_y"}, bus.y, ref_sel(a, b, sel));
        if (model_known) check({tag, "_yq_pre"}, bus.y_q, exp_q());
        clock_edge(tag);
    endtask

    initial begin
        logic             probe;
        logic [WIDTH-1:0] agree;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        logic             rr;

        probe      = 1'bx;
        four_state = (probe === 1'bx);

        rst = 1'b1; bus.a = '0; bus.b = '0; bus.sel = 1'b0;
        cur_a = '0; cur_b = '0; cur_sel = 1'b0; cur_rst = 1'b1; model_q = '0;

        // Reset for two edges, then directed selection steps.
        apply(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, "rst1");
        apply(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, "rst2");
        apply(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, "sel_a");
        apply(32'h00000000, 32'h55555555, 1'b1, 1'b0, "a_zero");
        apply(32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, "b_ignored");
        apply(32'hA5A5A5A5, 32'hFFFFFFFF, 1'b1, 1'b0, "a_a5");
        apply(32'hA5A5A5A5, 32'hDDDDDDDD, 1'b0, 1'b0, "sel_b");

        // Unknown select between edges: agreeing bits survive.
        @(negedge clk);
        bus.sel = 1'bx;
        #1;
        agree = ~(cur_a ^ cur_b);
        check("x_agree", bus.y & agree, cur_a & agree);
        check("x_bit31", {31'b0, bus.y[31]}, 32'd1);
        if (four_state) check("x_bit30", {31'b0, bus.y[30]}, {31'b0, 1'bx});
        bus.sel = cur_sel;
        clock_edge("x_restore");

        // Reset, release with a capture, then reset mid-stream.
        apply(32'h12345678, 32'hDDDDDDDD, 1'b1, 1'b1, "rst_again");
        apply(32'h12345678, 32'hDDDDDDDD, 1'b1, 1'b0, "release");
        apply(32'h87654321, 32'hDDDDDDDD, 1'b1, 1'b0, "stream");
        apply(32'h0F0F0F0F, 32'hDDDDDDDD, 1'b1, 1'b1, "rst_mid");
        apply(32'h0F0F0F0F, 32'hCAFEF00D, 1'b0, 1'b0, "resume");

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 7) == 0);
            apply(ra, rb, rs, rr, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
